// File: rtl/cg_seq_core.sv
// cg_seq_core: multi-stage coilgun sequencer, one shared accumulator/prescaler walking N_STAGES coils.
// Optional macro CG_DWELL_CAPTURE_EN adds O_DWELL, the per-stage on-time captured when each FIRE ends.
module cg_seq_core #(
  parameter int N_STAGES = 3,
  parameter int ACC_W    = 24,
  parameter int PRE_W    = 4,
  localparam int SW      = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                      clk,
  input  logic                      I_RST_N,
  input  logic                      I_TRIG,
  input  logic [N_STAGES-1:0]       I_GATE,
  input  logic                      I_ABORT,
  input  logic [N_STAGES*ACC_W-1:0] I_DLY,
  input  logic [N_STAGES*ACC_W-1:0] I_LMT,
  input  logic [N_STAGES*PRE_W-1:0] I_DIV,
  input  logic                      I_OE,
  input  logic                      I_EN,
  input  logic                      I_LEN,
  output logic [N_STAGES-1:0]       O_SOE,
  output logic [N_STAGES-1:0]       O_RTE,
  output logic                      O_BUSY,
  output logic                      O_FAULT,
  output logic                      O_DONE,
  output logic [SW-1:0]             O_STAGE,
  output logic [ACC_W-1:0]          O_ACC
`ifdef CG_DWELL_CAPTURE_EN
  ,output logic [N_STAGES*ACC_W-1:0] O_DWELL
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_FIRE  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam int NI = N_STAGES + 2;

  function automatic logic [ACC_W-1:0] sel_acc(input logic [N_STAGES*ACC_W-1:0] v,
                                               input logic [SW-1:0] idx);
    logic [ACC_W-1:0] r;
    r = {ACC_W{1'b0}};
    for (int k = 0; k < N_STAGES; k++) begin
      r = (idx == SW'(k)) ? v[k*ACC_W +: ACC_W] : r;
    end
    return r;
  endfunction

  function automatic logic [PRE_W-1:0] sel_pre(input logic [N_STAGES*PRE_W-1:0] v,
                                               input logic [SW-1:0] idx);
    logic [PRE_W-1:0] r;
    r = {PRE_W{1'b0}};
    for (int k = 0; k < N_STAGES; k++) begin
      r = (idx == SW'(k)) ? v[k*PRE_W +: PRE_W] : r;
    end
    return r;
  endfunction

  logic [NI-1:0]       sync1_q, sync2_q, sync3_q, edge_q, edge_d;
  state_e              state_q, state_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [N_STAGES-1:0] rte_q, rte_d;
  logic                done_q, done_d;
`ifdef CG_DWELL_CAPTURE_EN
  logic [N_STAGES*ACC_W-1:0] dwell_q, dwell_d;
`endif

  logic                trig_e_s, abort_e_s, gate_cur_s, last_s, tick_s;
  logic [SW-1:0]       stage_nxt_s;
  logic [N_STAGES-1:0] soe_s;

  // Edge pulse from the synchronised level; sync3 is the previous sample of sync2.
  always_comb begin
    edge_d = sync2_q & ~sync3_q;
  end

  always_ff @(posedge clk or negedge I_RST_N) begin
    if (!I_RST_N) begin
      sync1_q <= {NI{1'b0}};
      sync2_q <= {NI{1'b0}};
      sync3_q <= {NI{1'b0}};
      edge_q  <= {NI{1'b0}};
    end else begin
      sync1_q <= {I_ABORT, I_GATE, I_TRIG};
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= edge_d;
    end
  end

  assign trig_e_s    = edge_q[0];
  assign abort_e_s   = edge_q[NI-1];
  assign gate_cur_s  = edge_q[1 + int'(stage_q)];
  assign last_s      = (stage_q == SW'(N_STAGES - 1));
  assign stage_nxt_s = stage_q + SW'(1);
  assign tick_s      = (pre_q == sel_pre(I_DIV, stage_q));

  // Next-state logic; a gate edge is tested before the runtime limit so the gate wins a tie.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    acc_d   = acc_q;
    rte_d   = rte_q;
    done_d  = 1'b0;
`ifdef CG_DWELL_CAPTURE_EN
    dwell_d = dwell_q;
`endif
    if (!I_EN || abort_e_s) begin
      state_d = ST_IDLE;
      stage_d = {SW{1'b0}};
      acc_d   = {ACC_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trig_e_s) begin
            state_d = ST_DELAY;
            stage_d = {SW{1'b0}};
            acc_d   = sel_acc(I_DLY, {SW{1'b0}});
            rte_d   = {N_STAGES{1'b0}};
`ifdef CG_DWELL_CAPTURE_EN
            dwell_d = {(N_STAGES*ACC_W){1'b0}};
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (tick_s) begin
            if (acc_q == {ACC_W{1'b0}}) begin
              state_d = ST_FIRE;
              acc_d   = {ACC_W{1'b0}};
            end else begin
              acc_d   = acc_q - ACC_W'(1);
            end
          end else begin
            acc_d = acc_q;
          end
        end
        ST_FIRE: begin
          if (gate_cur_s) begin
`ifdef CG_DWELL_CAPTURE_EN
            dwell_d[int'(stage_q)*ACC_W +: ACC_W] = acc_q;
`endif
            if (last_s) begin
              state_d = ST_IDLE;
              stage_d = {SW{1'b0}};
              acc_d   = {ACC_W{1'b0}};
              done_d  = 1'b1;
            end else begin
              state_d = ST_DELAY;
              stage_d = stage_nxt_s;
              acc_d   = sel_acc(I_DLY, stage_nxt_s);
            end
          end else if (I_LEN && (acc_q >= sel_acc(I_LMT, stage_q))) begin
`ifdef CG_DWELL_CAPTURE_EN
            dwell_d[int'(stage_q)*ACC_W +: ACC_W] = acc_q;
`endif
            state_d = ST_FAULT;
            rte_d[stage_q] = 1'b1;
          end else if (tick_s && (acc_q != {ACC_W{1'b1}})) begin
            acc_d = acc_q + ACC_W'(1);
          end else begin
            acc_d = acc_q;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_IDLE;
          stage_d = {SW{1'b0}};
          acc_d   = {ACC_W{1'b0}};
        end
      endcase
    end
  end

  // Prescaler restarts on any state or stage change so each phase begins with a full period.
  always_comb begin
    if ((state_d != state_q) || (stage_d != stage_q)) begin
      pre_d = {PRE_W{1'b0}};
    end else if (tick_s) begin
      pre_d = {PRE_W{1'b0}};
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= ST_IDLE;
      stage_q <= {SW{1'b0}};
      acc_q   <= {ACC_W{1'b0}};
      pre_q   <= {PRE_W{1'b0}};
      rte_q   <= {N_STAGES{1'b0}};
      done_q  <= 1'b0;
`ifdef CG_DWELL_CAPTURE_EN
      dwell_q <= {(N_STAGES*ACC_W){1'b0}};
`endif
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      acc_q   <= acc_d;
      pre_q   <= pre_d;
      rte_q   <= rte_d;
      done_q  <= done_d;
`ifdef CG_DWELL_CAPTURE_EN
      dwell_q <= dwell_d;
`endif
    end
  end

  // Coil drive is gated by I_EN here so dropping enable cuts the coil without waiting a clock.
  always_comb begin
    soe_s = {N_STAGES{1'b0}};
    if ((state_q == ST_FIRE) && I_EN && I_OE) begin
      soe_s[stage_q] = 1'b1;
    end else begin
      soe_s = {N_STAGES{1'b0}};
    end
  end

  assign O_SOE   = soe_s;
  assign O_RTE   = rte_q;
  assign O_BUSY  = (state_q == ST_DELAY) || (state_q == ST_FIRE);
  assign O_FAULT = (state_q == ST_FAULT);
  assign O_DONE  = done_q;
  assign O_STAGE = stage_q;
  assign O_ACC   = acc_q;
`ifdef CG_DWELL_CAPTURE_EN
  assign O_DWELL = dwell_q;
`endif

endmodule

// File: tb/tb_cg_seq_core.sv
// Directed bench for cg_seq_core (N_STAGES=3, ACC_W=8, PRE_W=4), immediate-assertion checks.
module tb_cg_seq_core;

  logic        clk;
  logic        rst_n;
  logic        trig;
  logic [2:0]  gate;
  logic        abort_in;
  logic [23:0] dly;
  logic [23:0] lmt;
  logic [11:0] div;
  logic        oe, en, len;
  logic [2:0]  soe, rte;
  logic        busy, fault, done;
  logic [1:0]  stage;
  logic [7:0]  acc;
`ifdef CG_DWELL_CAPTURE_EN
  logic [23:0] dwell;
`endif

  int checks = 0;
  int errors = 0;

  cg_seq_core #(.N_STAGES(3), .ACC_W(8), .PRE_W(4)) dut (
    .clk(clk), .I_RST_N(rst_n), .I_TRIG(trig), .I_GATE(gate), .I_ABORT(abort_in),
    .I_DLY(dly), .I_LMT(lmt), .I_DIV(div), .I_OE(oe), .I_EN(en), .I_LEN(len),
    .O_SOE(soe), .O_RTE(rte), .O_BUSY(busy), .O_FAULT(fault), .O_DONE(done),
    .O_STAGE(stage), .O_ACC(acc)
`ifdef CG_DWELL_CAPTURE_EN
    , .O_DWELL(dwell)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; trig = 1'b0; gate = 3'b000; abort_in = 1'b0;
    dly = {8'd3, 8'd1, 8'd2}; lmt = {8'd255, 8'd255, 8'd255}; div = 12'h000;
    oe = 1'b1; en = 1'b1; len = 1'b0;

    // reset state
    #12;
    chk("rst_soe", {29'd0, soe}, 32'd0);
    chk("rst_rte", {29'd0, rte}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_stage", {30'd0, stage}, 32'd0);
    chk("rst_acc", {24'd0, acc}, 32'd0);
    step(1); rst_n = 1'b1; step(2);

    // full three-stage sequence, DIV=0, DLY={2,1,3}
    trig = 1'b1; step(3);
    chk("t1_sync_lat_idle", {31'd0, busy}, 32'd0);
    step(1);
    chk("t1_delay_busy", {31'd0, busy}, 32'd1);
    chk("t1_delay_acc", {24'd0, acc}, 32'd2);
    chk("t1_delay_soe", {29'd0, soe}, 32'd0);
    step(2);
    chk("t1_s0_acc0", {24'd0, acc}, 32'd0);
    chk("t1_s0_not_yet", {29'd0, soe}, 32'd0);
    step(1);
    chk("t1_s0_fire", {29'd0, soe}, 32'd1);
    step(6); gate = 3'b001; step(3);
    chk("t1_s0_acc9", {24'd0, acc}, 32'd9);
    chk("t1_s0_still", {29'd0, soe}, 32'd1);
    step(1); gate = 3'b000;
    chk("t1_s1_delay_soe", {29'd0, soe}, 32'd0);
    chk("t1_s1_stage", {30'd0, stage}, 32'd1);
    chk("t1_s1_acc", {24'd0, acc}, 32'd1);
    step(1);
    chk("t1_s1_not_yet", {29'd0, soe}, 32'd0);
    step(1);
    chk("t1_s1_fire", {29'd0, soe}, 32'd2);
    step(6); gate = 3'b010; step(3);
    chk("t1_s1_acc9", {24'd0, acc}, 32'd9);
    chk("t1_s1_still", {29'd0, soe}, 32'd2);
    step(1); gate = 3'b000;
    chk("t1_s2_stage", {30'd0, stage}, 32'd2);
    chk("t1_s2_acc", {24'd0, acc}, 32'd3);
    chk("t1_s2_delay_soe", {29'd0, soe}, 32'd0);
    step(3);
    chk("t1_s2_not_yet", {29'd0, soe}, 32'd0);
    step(1);
    chk("t1_s2_fire", {29'd0, soe}, 32'd4);
    step(6); gate = 3'b100; step(3);
    chk("t1_s2_still", {29'd0, soe}, 32'd4);
    chk("t1_no_early_done", {31'd0, done}, 32'd0);
    step(1); gate = 3'b000;
    chk("t1_end_soe", {29'd0, soe}, 32'd0);
    chk("t1_end_busy", {31'd0, busy}, 32'd0);
    chk("t1_done_pulse", {31'd0, done}, 32'd1);
    chk("t1_end_acc", {24'd0, acc}, 32'd0);
    chk("t1_end_stage", {30'd0, stage}, 32'd0);
    step(1);
    chk("t1_done_single", {31'd0, done}, 32'd0);

    // prescaler: DIV[0]=3, DLY[0]=2
    trig = 1'b0; div = 12'h003; step(4);
    trig = 1'b1; step(4);
    chk("t2_delay_acc2", {24'd0, acc}, 32'd2);
    step(3);
    chk("t2_hold_acc2", {24'd0, acc}, 32'd2);
    step(1);
    chk("t2_acc1", {24'd0, acc}, 32'd1);
    step(4);
    chk("t2_acc0", {24'd0, acc}, 32'd0);
    step(3);
    chk("t2_not_yet", {29'd0, soe}, 32'd0);
    step(1);
    chk("t2_fire_at_12", {29'd0, soe}, 32'd1);
    div = 12'h000;

    // runtime limit on stage 1
    lmt = {8'd255, 8'd5, 8'd200}; len = 1'b1;
    gate = 3'b001; step(4); gate = 3'b000;
    chk("t3_s1_stage", {30'd0, stage}, 32'd1);
    chk("t3_s1_acc", {24'd0, acc}, 32'd1);
    step(2);
    chk("t3_s1_fire", {29'd0, soe}, 32'd2);
    step(5);
    chk("t3_acc5", {24'd0, acc}, 32'd5);
    chk("t3_soe_before", {29'd0, soe}, 32'd2);
    chk("t3_no_fault_yet", {31'd0, fault}, 32'd0);
    step(1);
    chk("t3_soe_off", {29'd0, soe}, 32'd0);
    chk("t3_fault", {31'd0, fault}, 32'd1);
    chk("t3_rte", {29'd0, rte}, 32'd2);
    chk("t3_stage_hold", {30'd0, stage}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    trig = 1'b0; step(4); trig = 1'b1; step(4);
    chk("t3_trig_ignored", {31'd0, fault}, 32'd1);
    abort_in = 1'b1; step(3);
    chk("t3_abort_lat", {31'd0, fault}, 32'd1);
    step(1); abort_in = 1'b0;
    chk("t3_abort_clear", {31'd0, fault}, 32'd0);
    chk("t3_abort_stage", {30'd0, stage}, 32'd0);
    chk("t3_abort_acc", {24'd0, acc}, 32'd0);
    chk("t3_rte_kept", {29'd0, rte}, 32'd2);
    trig = 1'b0; step(4); trig = 1'b1; step(4);
    chk("t3_retrig_busy", {31'd0, busy}, 32'd1);
    chk("t3_rte_cleared", {29'd0, rte}, 32'd0);

    // gate and limit in the same clock: gate wins
    step(3);
    chk("t4_s0_fire", {29'd0, soe}, 32'd1);
    gate = 3'b001; step(4); gate = 3'b000;
    chk("t4_s1_stage", {30'd0, stage}, 32'd1);
    step(2);
    chk("t4_s1_fire", {29'd0, soe}, 32'd2);
    step(2); gate = 3'b010; step(3);
    chk("t4_acc5", {24'd0, acc}, 32'd5);
    step(1); gate = 3'b000;
    chk("t4_s2_stage", {30'd0, stage}, 32'd2);
    chk("t4_no_fault", {31'd0, fault}, 32'd0);
    chk("t4_rte_zero", {29'd0, rte}, 32'd0);
    chk("t4_s2_acc", {24'd0, acc}, 32'd3);
    abort_in = 1'b1; step(4); abort_in = 1'b0;
    chk("t4_abort_idle", {31'd0, busy}, 32'd0);

    // foreign gate ignored, then enable dropped mid-FIRE
    trig = 1'b0; step(4); trig = 1'b1; step(4); step(3);
    chk("t5_s0_fire", {29'd0, soe}, 32'd1);
    gate = 3'b100; step(5); gate = 3'b000;
    chk("t5_gate2_ignored_soe", {29'd0, soe}, 32'd1);
    chk("t5_gate2_ignored_stage", {30'd0, stage}, 32'd0);
    en = 1'b0; #1;
    chk("t5_en_soe_comb", {29'd0, soe}, 32'd0);
    chk("t5_en_still_busy", {31'd0, busy}, 32'd1);
    step(1);
    chk("t5_en_idle", {31'd0, busy}, 32'd0);
    chk("t5_en_acc", {24'd0, acc}, 32'd0);
    en = 1'b1;

    // asynchronous reset mid-FIRE, then release behaviour
    trig = 1'b0; step(4); trig = 1'b1; step(4); step(3);
    chk("t6_s0_fire", {29'd0, soe}, 32'd1);
    #2; rst_n = 1'b0; #1;
    chk("t6_rst_soe", {29'd0, soe}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_acc", {24'd0, acc}, 32'd0);
    chk("t6_rst_stage", {30'd0, stage}, 32'd0);
    trig = 1'b0; #2; rst_n = 1'b1;
    step(6);
    chk("t6_no_action", {31'd0, busy}, 32'd0);
    #2; rst_n = 1'b0; #1;
    trig = 1'b1; rst_n = 1'b1;
    step(3);
    chk("t6_aligned_wait", {31'd0, busy}, 32'd0);
    step(1);
    chk("t6_aligned_taken", {31'd0, busy}, 32'd1);
    chk("t6_aligned_acc", {24'd0, acc}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cg_seq_core.md
Name: cg_seq_core

Overview:
- Multi-stage coilgun sequencer and the parametrised successor of the single-coil core.
- Drives N_STAGES solenoid enables in order from one external trigger and per-stage gate sensors.
- A per-stage delay counts down from trigger/previous gate, then the stage fires. The stage turns off on its own gate or on a per-stage runtime limit.
- Uses one shared accumulator and prescaler, since only one stage is active at a time. Sits between the control-register block (which supplies DLY/LMT/DIV/OE/EN/LEN) and the coil drivers.

Parameters:
- N_STAGES, 3, number of coils/gates (1..16).
- ACC_W, 24, accumulator, delay and limit width.
- PRE_W, 4, per-stage prescaler select width.

Ports:
- clk  in  1  system clock
- I_RST_N  in  1  asynchronous, active-low reset
- I_TRIG  in  1  fire request; async level, rising edge used
- I_GATE  in  N_STAGES  gate sensors, bit k = stage k; rising edge used
- I_ABORT  in  1  soft abort / fault clear; rising edge used
- I_DLY  in  N_STAGES*ACC_W  per-stage delay, stage k at [k*ACC_W +: ACC_W]
- I_LMT  in  N_STAGES*ACC_W  per-stage on-time limit, same packing
- I_DIV  in  N_STAGES*PRE_W  per-stage prescale value; tick every I_DIV+1 clocks
- I_OE  in  1  output enable (CREG)
- I_EN  in  1  logic enable (CREG)
- I_LEN  in  1  limit enable (CREG)
- O_SOE  out  N_STAGES  solenoid enables, at most one bit set
- O_RTE  out  N_STAGES  sticky per-stage runtime-exceeded flags
- O_BUSY  out  1  high in DELAY or FIRE
- O_FAULT  out  1  high in FAULT
- O_DONE  out  1  one-clock pulse when the last stage's gate is seen
- O_STAGE  out  max(1,$clog2(N_STAGES))  current stage index
- O_ACC  out  ACC_W  accumulator value

Behaviour:
- Reset (I_RST_N low, async): state IDLE, stage 0, ACC 0, prescaler 0, synchronisers 0. All outputs 0.
- Input conditioning:
  - I_TRIG, each I_GATE bit and I_ABORT pass through a 2-flop synchroniser plus a registered rising-edge detector.
  - An input edge acts in the 3rd rising clk after it; state change is visible on outputs 1 clock later.
- Tick: prescaler counts 0..I_DIV[stage] and ticks when equal, then clears to 0. It also clears on every state or stage change. I_DIV=0 gives a tick every clock.
- States:
  - IDLE: on trig edge with I_EN=1 → DELAY, stage 0, ACC←I_DLY[0], all O_RTE cleared.
  - DELAY: on tick, if ACC==0 → FIRE (ACC←0), else ACC←ACC-1. I_DLY=0 enters FIRE on the first tick.
  - FIRE: O_SOE[stage]=I_OE. On tick, ACC←ACC+1, saturating at all-ones.
    - Gate edge for the current stage, when stage<N_STAGES-1 → DELAY, stage+1, ACC←I_DLY[stage+1].
    - Same gate edge when stage==N_STAGES-1 → IDLE with O_DONE pulse.
    - Else if I_LEN=1 and ACC>=I_LMT[stage] → O_RTE[stage]←1, go to FAULT.
  - FAULT: all O_SOE 0; O_STAGE holds the faulting stage. Leaves only on abort edge → IDLE.
- Priority, highest first:
  - Async reset.
  - I_EN=0: O_SOE forced 0 combinationally, state → IDLE next clock, O_RTE kept.
  - Abort edge: any state → IDLE, stage 0, ACC 0.
  - Gate over limit in the same cycle: gate wins.
- Ignored events:
  - Trig edges outside IDLE.
  - Gate edges of non-current stages.
  - Gate edges in DELAY. These are consumed and not queued.
- O_ACC = ACC; O_BUSY = (DELAY|FIRE); O_FAULT = (state==FAULT).
- I_DLY, I_LMT and I_DIV are sampled live. Changes take effect on the next compare or load.

Optional Feature:
- Macro CG_DWELL_CAPTURE_EN.
- Defined: adds output O_DWELL (N_STAGES*ACC_W). On leaving FIRE for stage k via gate or limit, ACC is latched into slice k. All slices clear to 0 on reset and on entry to DELAY from IDLE.
- Undefined: port and registers absent; all other behaviour identical.

Test Plan:
- N=3, ACC_W=8, DIV all 0, DLY={2,1,3}, LEN=0, EN=OE=1. Trig, then gate0, gate1, gate2 each 10 clk into FIRE → O_SOE 001→010→100 in order, one-hot, each FIRE starts DLY+1 ticks after the preceding event. O_DONE single pulse; final state IDLE, ACC=0.
- DIV[0]=3, DLY[0]=2, trig → ACC 2→1→0 at 4-clock spacing, O_SOE[0] rises 12 clocks after DELAY entry.
- LEN=1, LMT[1]=5, no gate1 → O_SOE[1] drops when ACC reaches 5, O_RTE=010, O_FAULT=1. Trig ignored; abort edge → IDLE, O_FAULT=0; next trig clears O_RTE.
- Gate1 edge and limit reached for stage 1 in the same clock → advance to stage 2 DELAY, O_RTE[1]=0.
- I_EN dropped mid-FIRE stage 0 → O_SOE=0 same cycle, IDLE next clock. Gate2 edge while in stage 0 FIRE → ignored.
- I_RST_N low mid-FIRE without a clk edge → all outputs 0 immediately. After release, no action until a new trig edge; a trig edge aligned to release is taken 3 clocks later.
